// File: rtl/lcd_4bit_driver.sv
// ---------------------------------------------------------------------------
// lcd_4bit_driver
//   Autonomous HD44780-compatible character LCD driver on the 4-bit bus.
//   After reset it waits for panel power-up, runs the nibble init sequence
//   and the configuration bytes, then refreshes two 16-character rows
//   forever. Each row is snapshotted right after its address command so
//   that every pass over a row shows one coherent text image.
//
// Ports
//   clk        in   1    system clock (50 MHz nominal)
//   rst        in   1    asynchronous active-high reset
//   row_a      in   128  top-row ASCII, [127:120] = column 0
//   row_b      in   128  bottom-row ASCII, same packing
//   init_done  out  1    high once init + configuration completed
//   LCD_E      out  1    enable strobe
//   LCD_RS     out  1    0 = command, 1 = data
//   LCD_RW     out  1    tied low (write-only)
//   LCD_D      out  4    data nibble, holds its last value between transfers
// ---------------------------------------------------------------------------
module lcd_4bit_driver #(
   parameter int T_PWR   = 750000,
   parameter int T_INIT1 = 205000,
   parameter int T_INIT2 = 5000,
   parameter int T_CMD   = 2000,
   parameter int T_CLR   = 82000,
   parameter int T_SETUP = 2,
   parameter int T_PULSE = 12,
   parameter int T_NIB   = 50
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] row_a,
   input  logic [127:0] row_b,
   output logic         init_done,
   output logic         LCD_E,
   output logic         LCD_RS,
   output logic         LCD_RW,
   output logic [3:0]   LCD_D
);

   localparam int M1   = (T_PWR > T_INIT1) ? T_PWR : T_INIT1;
   localparam int M2   = (T_CLR > T_INIT2) ? T_CLR : T_INIT2;
   localparam int M3   = (T_CMD > T_NIB)   ? T_CMD : T_NIB;
   localparam int M4   = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
   localparam int M12  = (M1 > M2) ? M1 : M2;
   localparam int M34  = (M3 > M4) ? M3 : M4;
   localparam int MAXP = (M12 > M34) ? M12 : M34;
   localparam int CW   = $clog2(MAXP + 1);

   typedef enum logic [2:0] {
      PWR_WAIT, INIT, CFG, ADDR_A, CHARS_A, ADDR_B, CHARS_B
   } main_t;

   typedef enum logic [1:0] {SETUP, E_HI, HOLD, WAIT} nib_t;

   main_t          main_st;
   nib_t           nib_st;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  gap;        // wait after the nibble in flight
   logic [3:0]     idx;        // init nibble / cfg byte / column index
   logic           low;        // nibble in flight is a byte's low half
   logic [7:0]     cur_byte;
   logic [127:0]   snap;

   // Next-nibble decision, evaluated when the current gap expires
   main_t          n_main;
   logic [3:0]     n_idx;
   logic           n_low, n_rs;
   logic [3:0]     n_d;
   logic [CW-1:0]  n_gap;
   logic [7:0]     n_byte;
   logic           load_hi, hi_rs, take_snap, set_done;
   logic [7:0]     hi_byte;
   logic [127:0]   snap_src;
   logic           pwr_done, step;

   function automatic logic [7:0] cfg_byte(input logic [3:0] i);
      case (i)
         4'd0:    return 8'h28;
         4'd1:    return 8'h06;
         4'd2:    return 8'h0C;
         default: return 8'h01;
      endcase
   endfunction

   // Column c sits at bit offset 8*(15-c); for a 4-bit c that is {~c, 3'b0}.
   function automatic logic [7:0] col_byte(input logic [127:0] r, input logic [3:0] c);
      return r[{~c, 3'b000} +: 8];
   endfunction

   assign LCD_RW   = 1'b0;
   assign pwr_done = (main_st == PWR_WAIT) && (cnt == CW'(T_PWR - 1));
   // HOLD is the first gap cycle, WAIT supplies the rest: gap cycles in total.
   assign step     = (main_st != PWR_WAIT) &&
                     (((nib_st == HOLD) && (gap == CW'(1))) ||
                      ((nib_st == WAIT) && (cnt == gap - CW'(1))));

   // NOTE: every signal gets a default first so no path leaves one unassigned
   // and no latch is inferred.
   always_comb begin
      n_main    = main_st;
      n_idx     = idx;
      n_low     = 1'b0;
      n_rs      = 1'b0;
      n_d       = 4'h0;
      n_gap     = CW'(T_NIB);
      n_byte    = cur_byte;
      load_hi   = 1'b0;
      hi_rs     = 1'b0;
      hi_byte   = 8'h00;
      take_snap = 1'b0;
      set_done  = 1'b0;
      snap_src  = row_a;

      if (main_st == INIT) begin
         if (idx == 4'd3) begin
            n_main  = CFG;
            n_idx   = 4'd0;
            load_hi = 1'b1;
            hi_byte = cfg_byte(4'd0);
         end else begin
            n_idx = idx + 4'd1;
            n_d   = (idx == 4'd2) ? 4'h2 : 4'h3;
            n_gap = (idx == 4'd0) ? CW'(T_INIT2) : CW'(T_CMD);
         end
      end else if (!low) begin
         // Second half of the current byte, then the post-byte wait.
         n_low = 1'b1;
         n_rs  = LCD_RS;
         n_d   = cur_byte[3:0];
         n_gap = (main_st == CFG && idx == 4'd3) ? CW'(T_CLR) : CW'(T_CMD);
      end else begin
         load_hi = 1'b1;
         case (main_st)
            CFG: begin
               if (idx == 4'd3) begin
                  n_main   = ADDR_A;
                  n_idx    = 4'd0;
                  hi_byte  = 8'h80;
                  set_done = 1'b1;
               end else begin
                  n_idx   = idx + 4'd1;
                  hi_byte = cfg_byte(idx + 4'd1);
               end
            end
            ADDR_A: begin
               // Column 0 comes straight from the row being captured now.
               n_main    = CHARS_A;
               n_idx     = 4'd0;
               hi_rs     = 1'b1;
               hi_byte   = col_byte(row_a, 4'd0);
               take_snap = 1'b1;
               snap_src  = row_a;
            end
            ADDR_B: begin
               n_main    = CHARS_B;
               n_idx     = 4'd0;
               hi_rs     = 1'b1;
               hi_byte   = col_byte(row_b, 4'd0);
               take_snap = 1'b1;
               snap_src  = row_b;
            end
            CHARS_A, CHARS_B: begin
               if (idx == 4'd15) begin
                  n_main  = (main_st == CHARS_A) ? ADDR_B : ADDR_A;
                  n_idx   = 4'd0;
                  hi_byte = (main_st == CHARS_A) ? 8'hC0 : 8'h80;
               end else begin
                  n_idx   = idx + 4'd1;
                  hi_rs   = 1'b1;
                  hi_byte = col_byte(snap, idx + 4'd1);
               end
            end
            default: ;
         endcase
      end

      if (load_hi) begin
         n_byte = hi_byte;
         n_d    = hi_byte[7:4];
         n_rs   = hi_rs;
         n_gap  = CW'(T_NIB);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_st   <= PWR_WAIT;
         nib_st    <= SETUP;
         cnt       <= '0;
         gap       <= '0;
         idx       <= 4'd0;
         low       <= 1'b0;
         cur_byte  <= 8'h00;
         init_done <= 1'b0;
         LCD_E     <= 1'b0;
         LCD_RS    <= 1'b0;
         LCD_D     <= 4'h0;
      end else if (main_st == PWR_WAIT) begin
         if (pwr_done) begin
            main_st <= INIT;
            nib_st  <= SETUP;
            cnt     <= '0;
            idx     <= 4'd0;
            low     <= 1'b0;
            LCD_RS  <= 1'b0;
            LCD_D   <= 4'h3;
            gap     <= CW'(T_INIT1);
         end else begin
            cnt <= cnt + CW'(1);
         end
      end else if (step) begin
         // RS/D only change here, a full gap after E fell.
         main_st  <= n_main;
         idx      <= n_idx;
         low      <= n_low;
         LCD_RS   <= n_rs;
         LCD_D    <= n_d;
         gap      <= n_gap;
         cur_byte <= n_byte;
         nib_st   <= SETUP;
         cnt      <= '0;
         if (set_done) init_done <= 1'b1;
      end else begin
         case (nib_st)
            SETUP: begin
               if (cnt == CW'(T_SETUP - 1)) begin
                  LCD_E  <= 1'b1;
                  nib_st <= E_HI;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            E_HI: begin
               if (cnt == CW'(T_PULSE - 1)) begin
                  LCD_E  <= 1'b0;
                  nib_st <= HOLD;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            HOLD: begin
               nib_st <= WAIT;
               cnt    <= CW'(1);
            end
            default: cnt <= cnt + CW'(1);
         endcase
      end
   end

   // NOTE: the row snapshot is pure data, always written before it is read,
   // so it carries no reset.
   always_ff @(posedge clk) begin
      if (!rst && take_snap && step) snap <= snap_src;
   end

endmodule

// File: tb/tb_lcd_4bit_driver.sv
// ---------------------------------------------------------------------------
// tb_lcd_4bit_driver
//   Self-checking bench for lcd_4bit_driver with shortened timing. A monitor
//   decodes every LCD_E fall and compares it against an expected nibble
//   stream built from the panel protocol (init nibbles, config bytes, then
//   alternating row passes sampled once per pass). Rows are changed at
//   random columns mid-pass to exercise snapshot coherence; a reset is
//   fired during an E-high data nibble to check the async restart.
// ---------------------------------------------------------------------------
module tb_lcd_4bit_driver;

   localparam int T_PWR   = 20;
   localparam int T_INIT1 = 10;
   localparam int T_INIT2 = 5;
   localparam int T_CMD   = 4;
   localparam int T_CLR   = 8;
   localparam int T_SETUP = 2;
   localparam int T_PULSE = 3;
   localparam int T_NIB   = 3;
   localparam int HALF    = 34;   // address byte + 16 chars, in nibbles
   localparam int NINIT   = 12;   // init nibbles + config nibbles

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] row_a, row_b;
   logic         init_done, lcd_e, lcd_rs, lcd_rw;
   logic [3:0]   lcd_d;

   lcd_4bit_driver #(
      .T_PWR(T_PWR), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_CMD(T_CMD),
      .T_CLR(T_CLR), .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_NIB(T_NIB)
   ) dut (
      .clk(clk), .rst(rst), .row_a(row_a), .row_b(row_b),
      .init_done(init_done), .LCD_E(lcd_e), .LCD_RS(lcd_rs),
      .LCD_RW(lcd_rw), .LCD_D(lcd_d)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rs;
      logic [3:0] d;
      int         gap;
   } nib_t;

   nib_t   q[$];
   int     n_checks = 0;
   int     n_fail   = 0;
   int     nfall, cyc, prev_fall, prev_gap, hi_cnt, half;
   bit     have_prev, e_prev, id_prev;
   logic       cap_rs;
   logic [3:0] cap_d;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic finish_up();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   endtask

   task automatic push_nib(input logic rs, input logic [3:0] d, input int g);
      nib_t n;
      n.rs = rs; n.d = d; n.gap = g;
      q.push_back(n);
   endtask

   task automatic push_byte(input logic rs, input logic [7:0] b, input int w);
      push_nib(rs, b[7:4], T_NIB);
      push_nib(rs, b[3:0], w);
   endtask

   task automatic build_init();
      q.delete();
      push_nib(1'b0, 4'h3, T_INIT1);
      push_nib(1'b0, 4'h3, T_INIT2);
      push_nib(1'b0, 4'h3, T_CMD);
      push_nib(1'b0, 4'h2, T_CMD);
      push_byte(1'b0, 8'h28, T_CMD);
      push_byte(1'b0, 8'h06, T_CMD);
      push_byte(1'b0, 8'h0C, T_CMD);
      push_byte(1'b0, 8'h01, T_CLR);
   endtask

   // One row pass: address command, then the row as it stands now.
   task automatic gen_half();
      logic [127:0] r;
      r = (half % 2 == 0) ? row_a : row_b;
      push_byte(1'b0, (half % 2 == 0) ? 8'h80 : 8'hC0, T_CMD);
      for (int c = 0; c < 16; c++) push_byte(1'b1, r[8*(15-c) +: 8], T_CMD);
      half++;
   endtask

   task automatic rand_row(output logic [127:0] r);
      for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'(32 + $urandom_range(0, 94));
   endtask

   // Protocol monitor, sampling on the falling clock edge.
   always @(negedge clk) begin
      if (rst) begin
         check("reset_outputs", {init_done, lcd_e, lcd_rs, lcd_rw, lcd_d}, 32'h0);
         build_init();
         nfall = 0; half = 0; hi_cnt = 0; cyc = 0;
         have_prev = 0; e_prev = 0; id_prev = 0;
      end else begin
         nib_t exp_n;
         cyc++;
         if (lcd_rw !== 1'b0) check("rw_low", lcd_rw, 0);
         if (lcd_e) begin
            if (!e_prev) begin
               cap_rs = lcd_rs; cap_d = lcd_d; hi_cnt = 1;
            end else begin
               hi_cnt++;
               check("stable_while_e", {lcd_rs, lcd_d}, {cap_rs, cap_d});
            end
         end else if (e_prev) begin
            check("pulse_width", hi_cnt, T_PULSE);
            if (q.size() == 0) gen_half();
            exp_n = q.pop_front();
            check($sformatf("nibble_%0d", nfall), {cap_rs, cap_d}, {exp_n.rs, exp_n.d});
            if (have_prev)
               check($sformatf("fall_gap_%0d", nfall), cyc - prev_fall, prev_gap + T_SETUP + T_PULSE);
            check("init_done_at_fall", init_done, (nfall >= NINIT) ? 1 : 0);
            prev_gap = exp_n.gap; prev_fall = cyc; have_prev = 1; nfall++;
         end
         if (init_done && !id_prev) begin
            check("init_done_after_clr", cyc - prev_fall, T_CLR);
            check("init_done_after_nibble", nfall, NINIT);
         end
         e_prev  = lcd_e;
         id_prev = init_done;
      end
   end

   task automatic wait_falls(input int n);
      int b = 0;
      while (nfall < n && b < 3000) begin
         @(negedge clk);
         b++;
      end
      if (nfall < n) begin
         check("timeout_falls", nfall, n);
         finish_up();
      end
   endtask

   task automatic first_rise();
      int c = 0;
      while (c < T_PWR + T_SETUP + 50) begin
         @(negedge clk);
         c++;
         if (lcd_e) break;
      end
      check("first_rise_cycle", c, T_PWR + T_SETUP);
      check("first_rise_d", lcd_d, 4'h3);
      check("first_rise_rs", lcd_rs, 1'b0);
   endtask

   initial begin
      #200000;
      check("watchdog", 1, 0);
      finish_up();
   end

   initial begin
      rst   = 1'b1;
      row_a = "HELLO WORLD     ";
      row_b = "TEMP 25.0C      ";
      repeat (10) @(negedge clk);
      rst = 1'b0;
      first_rise();

      // Column 5 of the first top-row pass is in flight: swap the text.
      wait_falls(NINIT + 3 + 2 * 5);
      row_a = {16{8'h41}};

      // Random mid-pass changes; each must only show on the row's next pass.
      for (int h = 1; h <= 6; h++) begin
         int col;
         logic [127:0] r;
         col = $urandom_range(0, 15);
         wait_falls(NINIT + HALF * h + 3 + 2 * col);
         rand_row(r);
         if (h % 2 == 1) row_b = r; else row_a = r;
         if (h >= 2) begin
            rand_row(r);
            if (h % 2 == 1) row_a = r; else row_b = r;
         end
      end

      // Reset while E is high on a data nibble.
      wait_falls(NINIT + HALF * 7 + 2 + 6);
      begin
         int b = 0;
         while (!(lcd_e && lcd_rs) && b < 100) begin
            @(negedge clk);
            b++;
         end
         check("found_data_pulse", {lcd_e, lcd_rs}, 2'b11);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_e_low", lcd_e, 1'b0);
      check("async_outputs", {init_done, lcd_rs, lcd_d}, 6'h0);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      first_rise();
      wait_falls(NINIT + HALF * 2);
      finish_up();
   end

endmodule

// File: doc/lcd_4bit_driver.md
Name: lcd_4bit_driver

Overview:
- Autonomous HD44780-compatible character LCD driver using the 4-bit bus.
- Sits downstream of the display-content logic in `main`, which drives two 16-character rows as packed ASCII vectors.
- After reset it runs the power-on init sequence, then refreshes both rows to the panel forever.
- Write-only: LCD_RW is held low.

Parameters:
- T_PWR, 750000: cycles of power-on wait before the first nibble (15 ms at 50 MHz).
- T_INIT1, 205000: wait after the first 0x3 init nibble (4.1 ms).
- T_INIT2, 5000: wait after the second 0x3 init nibble (100 us).
- T_CMD, 2000: wait after every byte and after init nibbles 3 and 4 (40 us).
- T_CLR, 82000: wait after the clear-display command 0x01 (1.64 ms).
- T_SETUP, 2: cycles RS/D are stable before E rises.
- T_PULSE, 12: cycles E is held high.
- T_NIB, 50: cycles from E falling on the high nibble to start of low-nibble setup.

Ports:
- clk  in  1  system clock, 50 MHz nominal.
- rst  in  1  reset; asynchronous, active-high.
- row_a  in  128  top-row text; [127:120] is column 0, [7:0] is column 15.
- row_b  in  128  bottom-row text; same packing as row_a.
- init_done  out  1  high once the init/config sequence has completed; stays high until reset.
- LCD_E  out  1  enable strobe.
- LCD_RS  out  1  0 = command, 1 = data.
- LCD_RW  out  1  constantly 0.
- LCD_D  out  4  data nibble.

Behaviour:
- Reset (async): LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_D=0, init_done=0. All counters and both FSMs return to their initial state.
- Reset asserted mid-transfer forces LCD_E low immediately. On release the full sequence restarts from PWR_WAIT; no partial transfer resumes.
- Main FSM states: PWR_WAIT, INIT, CFG, ADDR_A, CHARS_A, ADDR_B, CHARS_B.
- PWR_WAIT: count T_PWR cycles, then go to INIT.
- INIT: send single nibbles 0x3, 0x3, 0x3, 0x2 with RS=0. Waits after each: T_INIT1, T_INIT2, T_CMD, T_CMD.
- CFG: send bytes 0x28, 0x06, 0x0C, 0x01 with RS=0. Each is followed by T_CMD, except 0x01, which is followed by T_CLR. After the last wait, set init_done=1 and go to ADDR_A.
- ADDR_A: send command 0x80, wait T_CMD, snapshot row_a into an internal 128-bit register.
- CHARS_A: send 16 data bytes (RS=1) from the snapshot, column 0 first, T_CMD after each.
- ADDR_B / CHARS_B: same as ADDR_A / CHARS_A, using command 0xC0 and row_b.
- After CHARS_B, return to ADDR_A (continuous refresh).
- Snapshot rule: a row change during CHARS_x has no effect until that row's next ADDR_x snapshot. Glyphs within one row pass are always coherent.
- Nibble sub-FSM states: SETUP, E_HI, HOLD, WAIT.
  - SETUP: LCD_RS/LCD_D driven, LCD_E=0 for T_SETUP cycles.
  - E_HI: LCD_E=1 for T_PULSE cycles.
  - HOLD: LCD_E=0; LCD_RS/LCD_D remain stable for at least 1 cycle.
  - WAIT: count the gap.
- Byte transfer = high nibble, T_NIB gap, low nibble, then the post-byte wait.
- LCD_D/LCD_RS change only while LCD_E=0, never on or during an E-high cycle.
- Counters are wide enough for the largest parameter (at least 20 bits at defaults). A count of N means exactly N cycles, and N=1 is legal.
- LCD_D holds its last nibble between transfers; no tri-state.

Test Plan (benches override timing parameters to small values, e.g. T_PWR=20, T_INIT1=10, T_INIT2=5, T_CMD=4, T_CLR=8, T_SETUP=2, T_PULSE=3, T_NIB=3):
1. Hold rst=1 for 10 cycles → all outputs 0 and init_done=0 throughout. Release → no LCD_E rise for T_PWR+T_SETUP cycles; first rise has LCD_D=0x3, LCD_RS=0.
2. Monitor capturing (RS,D) on every LCD_E fall → sequence 3,3,3,2, then nibble pairs 2/8, 0/6, 0/C, 0/1. Gaps between E falls match the configured waits. init_done rises at the end of the T_CLR wait.
3. row_a = "HELLO WORLD     ", row_b = "TEMP 25.0C      " → decoded stream is 0x80, 16 data bytes 0x48,0x45,… with RS=1, then 0xC0, 0x54,… Stream then repeats with 0x80.
4. Change row_a to all 'A' (0x41) while CHARS_A column 5 is being sent → remaining columns of that pass keep the old text; the next pass sends 16×0x41.
5. Assert rst while LCD_E=1 during a data nibble → LCD_E=0 in the same timestep with no clock edge. After release, the step-1/step-2 sequence restarts and init_done=0 until it completes.
6. Throughout all tests → LCD_RW always 0, LCD_E high pulses exactly T_PULSE cycles, and no LCD_D/LCD_RS change while LCD_E=1.
